// File: rtl/branch_sequencer.sv
// Control-step generator for the branch instruction class (brzr/brnz/brpl/brmi).
// Sequences fetch, condition evaluation and conditional PC update, with fetch timeout and trap.
module branch_sequencer #(
    parameter int unsigned          OPCODE_W       = 5,
    parameter logic [OPCODE_W-1:0]  BR_OPCODE      = OPCODE_W'(5'b10010),
    parameter bit                   MEM_HANDSHAKE  = 1'b1,
    parameter int unsigned          TIMEOUT        = 15,
    parameter bit                   SKIP_NOT_TAKEN = 1'b1,
    parameter int unsigned          CNT_W          = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                con_ff,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Rout,
    output logic                CONin,
    output logic                Yin,
    output logic                Cout,
    output logic                BRANCH,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic [3:0]          step,
    output logic                done,
    output logic                illegal,
    output logic                fetch_err,
    output logic [CNT_W-1:0]    taken_cnt,
    output logic [CNT_W-1:0]    skip_cnt
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] T0   = 4'd1;
    localparam logic [3:0] T1   = 4'd2;
    localparam logic [3:0] T2   = 4'd3;
    localparam logic [3:0] T3   = 4'd4;
    localparam logic [3:0] T4   = 4'd5;
    localparam logic [3:0] T5   = 4'd6;
    localparam logic [3:0] T6   = 4'd7;
    localparam logic [3:0] TRAP = 4'd8;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ferr_q, ferr_d;
    logic [CNT_W-1:0]  taken_q, taken_d;
    logic [CNT_W-1:0]  skip_q, skip_d;

    logic is_branch;
    logic skip_path;

    assign is_branch = (ir_opcode == BR_OPCODE);
    assign skip_path = SKIP_NOT_TAKEN && !con_ff;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ferr_d  = ferr_q;
        taken_d = taken_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (run && !ferr_q) state_d = T0;
            end
            T0: begin
                state_d = T1;
                wait_d  = '0;
            end
            T1: begin
                // mem_ready on the last allowed cycle still completes the fetch
                if (!MEM_HANDSHAKE || mem_ready) begin
                    state_d = T2;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            T2: state_d = T3;
            T3: state_d = is_branch ? T4 : TRAP;
            TRAP: state_d = IDLE;
            T4: begin
                if (skip_path) begin
                    skip_d  = skip_q + CNT_W'(1);
                    state_d = run ? T0 : IDLE;
                end else begin
                    state_d = T5;
                end
            end
            T5: state_d = T6;
            T6: begin
                if (con_ff) taken_d = taken_q + CNT_W'(1);
                else        skip_d  = skip_q + CNT_W'(1);
                state_d = run ? T0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            wait_q  <= '0;
            ferr_q  <= 1'b0;
            taken_q <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ferr_q  <= ferr_d;
            taken_q <= taken_d;
            skip_q  <= skip_d;
        end
    end

    // Only one of PCout/Rout/MDRout/Zlowout is raised in any state.
    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        BRANCH  = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
            end
            T1: begin
                IncPC = (wait_q == '0);
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Gra   = is_branch;
                Rout  = is_branch;
                CONin = is_branch;
            end
            TRAP: illegal = 1'b1;
            T4: begin
                if (skip_path) begin
                    done = 1'b1;
                end else begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            T5: begin
                Cout   = 1'b1;
                BRANCH = 1'b1;
                Zin    = 1'b1;
            end
            T6: begin
                Zlowout = 1'b1;
                PCin    = con_ff;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign step      = state_q;
    assign fetch_err = ferr_q;
    assign taken_cnt = taken_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: two configurations share stimulus, one is checked at a time.
module tb_branch_sequencer;

    localparam logic [4:0] BR = 5'b10010;

    localparam logic [15:0] S_PCOUT = 16'h8000, S_MARIN = 16'h4000, S_INCPC = 16'h2000;
    localparam logic [15:0] S_READ = 16'h1000, S_MDRIN = 16'h0800, S_MDROUT = 16'h0400;
    localparam logic [15:0] S_IRIN = 16'h0200, S_GRA = 16'h0100, S_ROUT = 16'h0080;
    localparam logic [15:0] S_CONIN = 16'h0040, S_YIN = 16'h0020, S_COUT = 16'h0010;
    localparam logic [15:0] S_BRANCH = 16'h0008, S_ZIN = 16'h0004, S_ZLOW = 16'h0002;
    localparam logic [15:0] S_PCIN = 16'h0001;

    localparam logic [15:0] F0  = S_PCOUT | S_MARIN;
    localparam logic [15:0] F1  = S_INCPC | S_READ | S_MDRIN;
    localparam logic [15:0] F1W = S_READ | S_MDRIN;
    localparam logic [15:0] F2  = S_MDROUT | S_IRIN;
    localparam logic [15:0] E3  = S_GRA | S_ROUT | S_CONIN;
    localparam logic [15:0] E4  = S_PCOUT | S_YIN;
    localparam logic [15:0] E5  = S_COUT | S_BRANCH | S_ZIN;
    localparam logic [15:0] E6T = S_ZLOW | S_PCIN;
    localparam logic [15:0] E6N = S_ZLOW;

    logic       clk = 1'b0;
    logic       clr, run, mem_ready, con_ff;
    logic [4:0] ir_opcode;
    logic       sel;

    logic [15:0] sb_a, sb_b;
    logic [3:0]  step_a, step_b;
    logic        done_a, done_b, ill_a, ill_b, fe_a, fe_b;
    logic [15:0] tk_a, sk_a;
    logic [1:0]  tk_b, sk_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] sb;
        logic        dn;
        logic        il;
        logic        fe;
        logic [15:0] tk;
        logic [15:0] sk;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_sequencer #(
        .MEM_HANDSHAKE(1'b0), .SKIP_NOT_TAKEN(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir_opcode(ir_opcode),
        .con_ff(con_ff),
        .PCout(sb_a[15]), .MARin(sb_a[14]), .IncPC(sb_a[13]), .Read(sb_a[12]),
        .MDRin(sb_a[11]), .MDRout(sb_a[10]), .IRin(sb_a[9]), .Gra(sb_a[8]), .Rout(sb_a[7]),
        .CONin(sb_a[6]), .Yin(sb_a[5]), .Cout(sb_a[4]), .BRANCH(sb_a[3]), .Zin(sb_a[2]),
        .Zlowout(sb_a[1]), .PCin(sb_a[0]),
        .step(step_a), .done(done_a), .illegal(ill_a), .fetch_err(fe_a),
        .taken_cnt(tk_a), .skip_cnt(sk_a)
    );

    branch_sequencer #(
        .MEM_HANDSHAKE(1'b1), .TIMEOUT(15), .SKIP_NOT_TAKEN(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir_opcode(ir_opcode),
        .con_ff(con_ff),
        .PCout(sb_b[15]), .MARin(sb_b[14]), .IncPC(sb_b[13]), .Read(sb_b[12]),
        .MDRin(sb_b[11]), .MDRout(sb_b[10]), .IRin(sb_b[9]), .Gra(sb_b[8]), .Rout(sb_b[7]),
        .CONin(sb_b[6]), .Yin(sb_b[5]), .Cout(sb_b[4]), .BRANCH(sb_b[3]), .Zin(sb_b[2]),
        .Zlowout(sb_b[1]), .PCin(sb_b[0]),
        .step(step_b), .done(done_b), .illegal(ill_b), .fetch_err(fe_b),
        .taken_cnt(tk_b), .skip_cnt(sk_b)
    );

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Push the expectation for the current cycle, sample at negedge, then move past next edge.
    task automatic chk(input string tag, input logic [3:0] st, input logic [15:0] sb,
                       input logic dn, input logic il, input logic fe,
                       input int tk, input int sk);
        exp_t e;
        e.tag = tag; e.st = st; e.sb = sb; e.dn = dn; e.il = il; e.fe = fe;
        e.tk = 16'(tk); e.sk = 16'(sk);
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        if (sel == 1'b0) begin
            cmp(e.tag, "step", {12'd0, step_a}, {12'd0, e.st});
            cmp(e.tag, "strobes", sb_a, e.sb);
            cmp(e.tag, "done", {15'd0, done_a}, {15'd0, e.dn});
            cmp(e.tag, "illegal", {15'd0, ill_a}, {15'd0, e.il});
            cmp(e.tag, "fetch_err", {15'd0, fe_a}, {15'd0, e.fe});
            cmp(e.tag, "taken_cnt", tk_a, e.tk);
            cmp(e.tag, "skip_cnt", sk_a, e.sk);
        end else begin
            cmp(e.tag, "step", {12'd0, step_b}, {12'd0, e.st});
            cmp(e.tag, "strobes", sb_b, e.sb);
            cmp(e.tag, "done", {15'd0, done_b}, {15'd0, e.dn});
            cmp(e.tag, "illegal", {15'd0, ill_b}, {15'd0, e.il});
            cmp(e.tag, "fetch_err", {15'd0, fe_b}, {15'd0, e.fe});
            cmp(e.tag, "taken_cnt", {14'd0, tk_b}, e.tk);
            cmp(e.tag, "skip_cnt", {14'd0, sk_b}, e.sk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir_opcode = BR; con_ff = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 16'h0, 0, 0, 0, 0, 0);
        clr = 1'b1; run = 1'b1;
        chk("idle_go", 0, 16'h0, 0, 0, 0, 0, 0);

        // Config A: no handshake, skip of not-taken path; taken branch first
        chk("a_t0", 1, F0, 0, 0, 0, 0, 0);
        chk("a_t1", 2, F1, 0, 0, 0, 0, 0);
        chk("a_t2", 3, F2, 0, 0, 0, 0, 0);
        chk("a_t3", 4, E3, 0, 0, 0, 0, 0);
        chk("a_t4", 5, E4, 0, 0, 0, 0, 0);
        chk("a_t5", 6, E5, 0, 0, 0, 0, 0);
        chk("a_t6", 7, E6T, 1, 0, 0, 0, 0);
        con_ff = 1'b0;
        chk("a_b2b_t0", 1, F0, 0, 0, 0, 1, 0);
        chk("a_nt_t1", 2, F1, 0, 0, 0, 1, 0);
        chk("a_nt_t2", 3, F2, 0, 0, 0, 1, 0);
        chk("a_nt_t3", 4, E3, 0, 0, 0, 1, 0);
        chk("a_nt_t4", 5, 16'h0, 1, 0, 0, 1, 0);
        run = 1'b0;
        chk("a_skip_t0", 1, F0, 0, 0, 0, 1, 1);
        chk("a_stop_t1", 2, F1, 0, 0, 0, 1, 1);
        chk("a_stop_t2", 3, F2, 0, 0, 0, 1, 1);
        chk("a_stop_t3", 4, E3, 0, 0, 0, 1, 1);
        chk("a_stop_t4", 5, 16'h0, 1, 0, 0, 1, 1);
        chk("a_stop_idle", 0, 16'h0, 0, 0, 0, 1, 2);
        chk("a_stay_idle", 0, 16'h0, 0, 0, 0, 1, 2);

        // Reset in the middle of T5
        run = 1'b1; con_ff = 1'b1;
        chk("a_r_idle", 0, 16'h0, 0, 0, 0, 1, 2);
        chk("a_r_t0", 1, F0, 0, 0, 0, 1, 2);
        chk("a_r_t1", 2, F1, 0, 0, 0, 1, 2);
        chk("a_r_t2", 3, F2, 0, 0, 0, 1, 2);
        chk("a_r_t3", 4, E3, 0, 0, 0, 1, 2);
        chk("a_r_t4", 5, E4, 0, 0, 0, 1, 2);
        clr = 1'b0;
        chk("a_r_t5", 6, E5, 0, 0, 0, 1, 2);
        chk("a_r_after", 0, 16'h0, 0, 0, 0, 0, 0);
        clr = 1'b1;

        // Config B: handshake, full T4-T6 always, 2-bit counters
        sel = 1'b1;
        chk("b_idle", 0, 16'h0, 0, 0, 0, 0, 0);
        chk("b_t0", 1, F0, 0, 0, 0, 0, 0);
        chk("b_t1_w1", 2, F1, 0, 0, 0, 0, 0);
        chk("b_t1_w2", 2, F1W, 0, 0, 0, 0, 0);
        chk("b_t1_w3", 2, F1W, 0, 0, 0, 0, 0);
        mem_ready = 1'b1;
        chk("b_t1_w4", 2, F1W, 0, 0, 0, 0, 0);
        chk("b_t2", 3, F2, 0, 0, 0, 0, 0);
        chk("b_t3", 4, E3, 0, 0, 0, 0, 0);
        chk("b_t4", 5, E4, 0, 0, 0, 0, 0);
        chk("b_t5", 6, E5, 0, 0, 0, 0, 0);
        chk("b_t6", 7, E6T, 1, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            chk("b_loop_t0", 1, F0, 0, 0, 0, k, 0);
            chk("b_loop_t1", 2, F1, 0, 0, 0, k, 0);
            chk("b_loop_t2", 3, F2, 0, 0, 0, k, 0);
            chk("b_loop_t3", 4, E3, 0, 0, 0, k, 0);
            chk("b_loop_t4", 5, E4, 0, 0, 0, k, 0);
            chk("b_loop_t5", 6, E5, 0, 0, 0, k, 0);
            chk("b_loop_t6", 7, E6T, 1, 0, 0, k, 0);
        end
        con_ff = 1'b0;
        chk("b_wrap_t0", 1, F0, 0, 0, 0, 0, 0);
        chk("b_nt_t1", 2, F1, 0, 0, 0, 0, 0);
        chk("b_nt_t2", 3, F2, 0, 0, 0, 0, 0);
        chk("b_nt_t3", 4, E3, 0, 0, 0, 0, 0);
        chk("b_nt_t4", 5, E4, 0, 0, 0, 0, 0);
        chk("b_nt_t5", 6, E5, 0, 0, 0, 0, 0);
        chk("b_nt_t6", 7, E6N, 1, 0, 0, 0, 0);

        // Illegal opcode
        ir_opcode = 5'b00011;
        chk("b_il_t0", 1, F0, 0, 0, 0, 0, 1);
        chk("b_il_t1", 2, F1, 0, 0, 0, 0, 1);
        chk("b_il_t2", 3, F2, 0, 0, 0, 0, 1);
        chk("b_il_t3", 4, 16'h0, 0, 0, 0, 0, 1);
        run = 1'b0;
        chk("b_trap", 8, 16'h0, 0, 1, 0, 0, 1);
        chk("b_il_idle", 0, 16'h0, 0, 0, 0, 0, 1);

        // Fetch timeout
        run = 1'b1; mem_ready = 1'b0; ir_opcode = BR;
        chk("b_to_idle", 0, 16'h0, 0, 0, 0, 0, 1);
        chk("b_to_t0", 1, F0, 0, 0, 0, 0, 1);
        chk("b_to_t1_first", 2, F1, 0, 0, 0, 0, 1);
        for (int i = 1; i < 15; i++) chk("b_to_t1", 2, F1W, 0, 0, 0, 0, 1);
        chk("b_to_err", 0, 16'h0, 0, 0, 1, 0, 1);
        chk("b_to_hold1", 0, 16'h0, 0, 0, 1, 0, 1);
        chk("b_to_hold2", 0, 16'h0, 0, 0, 1, 0, 1);
        clr = 1'b0;
        chk("b_to_clr", 0, 16'h0, 0, 0, 1, 0, 1);
        clr = 1'b1;
        chk("b_to_cleared", 0, 16'h0, 0, 0, 0, 0, 0);
        chk("b_to_restart", 1, F0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
